// File: rtl/mt9d111_capture_pkg.sv
// Shared definitions for the MT9D111 capture path: default frame geometry,
// FSM state encoding, coordinate width and a saturating counter helper.
package mt9d111_capture_pkg;

   localparam int CAM_H_WIDTH = 160;
   localparam int CAM_V_WIDTH = 128;
   localparam int COORD_W     = 11;

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_FRAME   = 2'd2,
      ST_SKIP    = 2'd3
   } cap_state_t;

   // Coordinate counters stop at all-ones so a runaway line or frame can
   // never wrap back into the valid range and emit bogus pixels.
   function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
      return (&v) ? v : v + COORD_W'(1);
   endfunction

endpackage

// File: rtl/mt9d111_capture_rgb565_to_gray.sv
// rgb565_to_gray: combinational luminance estimate from an RGB565 pixel.
// Channels are widened to 8 bits by replicating their MSBs, then weighted
// 77/150/29 (sum 256) so the >>8 yields an 8-bit luma that reaches 255.
module rgb565_to_gray (
   input  logic [15:0] i_rgb,
   output logic [7:0]  o_gray
);

   logic [7:0]  w_r8;
   logic [7:0]  w_g8;
   logic [7:0]  w_b8;
   logic [17:0] w_sum;

   assign w_r8  = {i_rgb[15:11], i_rgb[15:13]};
   assign w_g8  = {i_rgb[10:5],  i_rgb[10:9]};
   assign w_b8  = {i_rgb[4:0],   i_rgb[4:2]};

   assign w_sum = 18'd77  * {10'd0, w_r8}
                + 18'd150 * {10'd0, w_g8}
                + 18'd29  * {10'd0, w_b8};

   assign o_gray = 8'(w_sum >> 8);

endmodule

// File: rtl/mt9d111_capture.sv
// mt9d111_capture: receiver for the MT9D111 parallel interface. Registers
// VSYNC/HREF/D once, assembles high/low byte pairs into RGB565 pixels with
// X/Y tags, and checks line length and frame height.
// Optional luminance output is built when CAM_CAPTURE_GRAY_EN is defined;
// otherwise PIX_GRAY is tied to zero.
module mt9d111_capture
   import mt9d111_capture_pkg::*;
#(
   parameter int H_WIDTH = CAM_H_WIDTH,
   parameter int V_WIDTH = CAM_V_WIDTH
) (
   input  logic               CLOCK65,
   input  logic               RESET,
   input  logic               CAP_EN,
   input  logic               MT9D111_VSYNC,
   input  logic               MT9D111_HREF,
   input  logic [7:0]         MT9D111_D,
   output logic               PIX_VALID,
   output logic [15:0]        PIX_DATA,
   output logic [7:0]         PIX_GRAY,
   output logic [COORD_W-1:0] PIX_X,
   output logic [COORD_W-1:0] PIX_Y,
   output logic               FRAME_START,
   output logic               FRAME_END,
   output logic               LINE_ERR,
   output logic               FRAME_ERR,
   output logic [7:0]         FRAME_CNT
);

   localparam logic [COORD_W-1:0] H_W = COORD_W'(H_WIDTH);
   localparam logic [COORD_W-1:0] V_W = COORD_W'(V_WIDTH);

   // Input stage (s1) and its one-cycle-old VSYNC copy for edge detection.
   logic               r_vs1;
   logic               r_href1;
   logic [7:0]         r_d1;
   logic               r_vs2;

   cap_state_t         r_state;
   logic               r_phase;
   logic [7:0]         r_hi;
   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;
   logic               r_line_open;

   logic               r_pix_valid;
   logic [15:0]        r_pix_data;
   logic [COORD_W-1:0] r_pix_x;
   logic [COORD_W-1:0] r_pix_y;
   logic               r_frame_start;
   logic               r_frame_end;
   logic               r_line_err;
   logic               r_frame_err;
   logic [7:0]         r_frame_cnt;

   logic               w_vs_rise;
   logic               w_vs_fall;
   logic               w_in_frame;
   logic               w_byte;
   logic               w_pix_done;
   logic               w_emit;
   logic [15:0]        w_pix;
   logic [COORD_W-1:0] w_x_next;
   logic               w_phase_next;
   logic               w_line_close;
   logic               w_line_bad;
   logic [COORD_W-1:0] w_y_next;
   logic               w_frame_end;

   // Input register stage; it keeps sampling through reset so that the
   // SYNC state sees the true VSYNC level the moment reset is released.
   always_ff @(posedge CLOCK65) begin
      r_vs1   <= MT9D111_VSYNC;
      r_href1 <= MT9D111_HREF;
      r_d1    <= MT9D111_D;
      r_vs2   <= r_vs1;
   end

   assign w_vs_rise  = r_vs1 & ~r_vs2;
   assign w_vs_fall  = ~r_vs1 & r_vs2;
   assign w_in_frame = (r_state == ST_FRAME);
   assign w_byte     = w_in_frame & r_href1;
   assign w_pix_done = w_byte & r_phase;
   assign w_pix      = {r_hi, r_d1};
   assign w_emit     = w_pix_done & (r_x < H_W) & (r_y < V_W);

   // Byte/pixel counts including this cycle's byte, so a line closed by a
   // VSYNC fall in the same cycle as its last byte is judged complete.
   assign w_x_next     = w_pix_done ? sat_inc(r_x) : r_x;
   assign w_phase_next = w_byte ? ~r_phase : r_phase;

   // A line ends on the HREF fall, or is forced closed by VSYNC falling
   // while HREF is still high.
   assign w_line_close = w_in_frame &
                         ((r_line_open & ~r_href1) | (w_vs_fall & r_href1));
   assign w_line_bad   = (w_x_next != H_W) | w_phase_next;
   assign w_y_next     = w_line_close ? sat_inc(r_y) : r_y;
   assign w_frame_end  = w_in_frame & w_vs_fall;

`ifdef CAM_CAPTURE_GRAY_EN
   logic [7:0] w_gray;
   logic [7:0] r_pix_gray;

   rgb565_to_gray u_gray (
      .i_rgb  (w_pix),
      .o_gray (w_gray)
   );

   assign PIX_GRAY = r_pix_gray;
`else
   assign PIX_GRAY = 8'd0;
`endif

   // Capture FSM with byte assembly, geometry checks and registered outputs.
   always_ff @(posedge CLOCK65) begin
      if (RESET) begin
         r_state       <= ST_SYNC;
         r_phase       <= 1'b0;
         r_hi          <= 8'd0;
         r_x           <= '0;
         r_y           <= '0;
         r_line_open   <= 1'b0;
         r_pix_valid   <= 1'b0;
         r_pix_data    <= 16'd0;
         r_pix_x       <= '0;
         r_pix_y       <= '0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_line_err    <= 1'b0;
         r_frame_err   <= 1'b0;
         r_frame_cnt   <= 8'd0;
`ifdef CAM_CAPTURE_GRAY_EN
         r_pix_gray    <= 8'd0;
`endif
      end else begin
         r_pix_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_line_err    <= 1'b0;
         r_frame_err   <= 1'b0;

         case (r_state)
            ST_SYNC: begin
               if (!r_vs1) begin
                  r_state <= ST_WAIT_VS;
               end
            end

            ST_WAIT_VS: begin
               if (w_vs_rise) begin
                  if (CAP_EN) begin
                     r_frame_start <= 1'b1;
                     r_x           <= '0;
                     r_y           <= '0;
                     r_phase       <= 1'b0;
                     r_line_open   <= 1'b0;
                     r_state       <= ST_FRAME;
                  end else begin
                     r_state <= ST_SKIP;
                  end
               end
            end

            ST_SKIP: begin
               if (w_vs_fall) begin
                  r_state <= ST_WAIT_VS;
               end
            end

            ST_FRAME: begin
               if (w_byte && !r_phase) begin
                  r_hi <= r_d1;
               end

               if (w_emit) begin
                  r_pix_valid <= 1'b1;
                  r_pix_data  <= w_pix;
                  r_pix_x     <= r_x;
                  r_pix_y     <= r_y;
`ifdef CAM_CAPTURE_GRAY_EN
                  r_pix_gray  <= w_gray;
`endif
               end

               r_line_open <= r_href1 & ~w_vs_fall;

               if (w_line_close) begin
                  r_line_err <= w_line_bad;
                  r_x        <= '0;
                  r_phase    <= 1'b0;
                  r_y        <= w_y_next;
               end else begin
                  r_x        <= w_x_next;
                  r_phase    <= w_phase_next;
               end

               if (w_frame_end) begin
                  r_frame_end <= 1'b1;
                  r_frame_err <= (w_y_next != V_W);
                  r_frame_cnt <= r_frame_cnt + 8'd1;
                  r_state     <= ST_WAIT_VS;
               end
            end

            default: r_state <= ST_SYNC;
         endcase
      end
   end

   assign PIX_VALID   = r_pix_valid;
   assign PIX_DATA    = r_pix_data;
   assign PIX_X       = r_pix_x;
   assign PIX_Y       = r_pix_y;
   assign FRAME_START = r_frame_start;
   assign FRAME_END   = r_frame_end;
   assign LINE_ERR    = r_line_err;
   assign FRAME_ERR   = r_frame_err;
   assign FRAME_CNT   = r_frame_cnt;

endmodule

// File: tb/tb_mt9d111_capture.sv
// Testbench for mt9d111_capture with a reduced 16x12 geometry. Expected
// pixels (data, gray, X, Y and arrival cycle) are queued as bytes are driven;
// observed strobes are queued by a monitor and compared per frame.
// Build with CAM_CAPTURE_GRAY_EN defined to also check the luminance output.
module tb_mt9d111_capture;

   localparam int H  = 16;
   localparam int V  = 12;
   localparam int EW = 78;   // {data16, gray8, x11, y11, cycle32}

   // ---------------- clock / reset ----------------
   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        cap_en = 1'b0;
   logic        vs     = 1'b0;
   logic        href   = 1'b0;
   logic [7:0]  d      = 8'd0;

   logic        pix_valid;
   logic [15:0] pix_data;
   logic [7:0]  pix_gray;
   logic [10:0] pix_x;
   logic [10:0] pix_y;
   logic        frame_start;
   logic        frame_end;
   logic        line_err;
   logic        frame_err;
   logic [7:0]  frame_cnt;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mt9d111_capture #(.H_WIDTH(H), .V_WIDTH(V)) dut (
      .CLOCK65       (clk),
      .RESET         (rst),
      .CAP_EN        (cap_en),
      .MT9D111_VSYNC (vs),
      .MT9D111_HREF  (href),
      .MT9D111_D     (d),
      .PIX_VALID     (pix_valid),
      .PIX_DATA      (pix_data),
      .PIX_GRAY      (pix_gray),
      .PIX_X         (pix_x),
      .PIX_Y         (pix_y),
      .FRAME_START   (frame_start),
      .FRAME_END     (frame_end),
      .LINE_ERR      (line_err),
      .FRAME_ERR     (frame_err),
      .FRAME_CNT     (frame_cnt)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] obs_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   int n_fs = 0, n_fe = 0, n_le = 0, n_ferr = 0, n_ferr_alone = 0;
   int fe_cyc = 0, last_pix_cyc = 0;
   int exp_fs = 0, exp_fe = 0, exp_le = 0, exp_ferr = 0, exp_cnt = 0;

   bit          cap_active = 1'b0;
   int          pat_mode   = 0;
   int          line_bytes[64];
   logic [15:0] dir_px[3] = '{16'hF800, 16'h07E0, 16'hFFFF};

   // Monitor: records strobes and pulse counts away from the active edge.
   always @(negedge clk) begin
      if (pix_valid) begin
         obs_q.push_back({pix_data, pix_gray, pix_x, pix_y, 32'(cyc)});
         last_pix_cyc <= cyc;
      end
      if (frame_start) n_fs <= n_fs + 1;
      if (frame_end) begin
         n_fe   <= n_fe + 1;
         fe_cyc <= cyc;
      end
      if (line_err)  n_le   <= n_le + 1;
      if (frame_err) n_ferr <= n_ferr + 1;
      if (frame_err && !frame_end) n_ferr_alone <= n_ferr_alone + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

`ifdef CAM_CAPTURE_GRAY_EN
   function automatic logic [7:0] gray_of(input logic [15:0] p);
      int r8, g8, b8;
      r8 = {p[15:11], p[15:13]};
      g8 = {p[10:5],  p[10:9]};
      b8 = {p[4:0],   p[4:2]};
      return 8'((77 * r8 + 150 * g8 + 29 * b8) >> 8);
   endfunction
`endif

   function automatic logic [15:0] pix_value(input int x, input int y);
      case (pat_mode)
         0:       return 16'(y * H + x);
         2:       return (y == 0 && x < 3) ? dir_px[x] : 16'($urandom_range(0, 65535));
         default: return 16'($urandom_range(0, 65535));
      endcase
   endfunction

   task automatic drain_compare(input string tag);
      logic [EW-1:0] o, e;
      check({tag, "_pix_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check({tag, "_data"},  64'(o[77:62]), 64'(e[77:62]));
         check({tag, "_gray"},  64'(o[61:54]), 64'(e[61:54]));
         check({tag, "_x"},     64'(o[53:43]), 64'(e[53:43]));
         check({tag, "_y"},     64'(o[42:32]), 64'(e[42:32]));
         check({tag, "_cycle"}, 64'(o[31:0]),  64'(e[31:0]));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_events(input string tag);
      check({tag, "_frame_start_cnt"}, 64'(n_fs),   64'(exp_fs));
      check({tag, "_frame_end_cnt"},   64'(n_fe),   64'(exp_fe));
      check({tag, "_line_err_cnt"},    64'(n_le),   64'(exp_le));
      check({tag, "_frame_err_cnt"},   64'(n_ferr), 64'(exp_ferr));
      check({tag, "_frame_err_alone"}, 64'(n_ferr_alone), 64'd0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_pix_valid"},   64'(pix_valid),   64'd0);
      check({tag, "_pix_data"},    64'(pix_data),    64'd0);
      check({tag, "_pix_gray"},    64'(pix_gray),    64'd0);
      check({tag, "_pix_x"},       64'(pix_x),       64'd0);
      check({tag, "_pix_y"},       64'(pix_y),       64'd0);
      check({tag, "_frame_start"}, 64'(frame_start), 64'd0);
      check({tag, "_frame_end"},   64'(frame_end),   64'd0);
      check({tag, "_line_err"},    64'(line_err),    64'd0);
      check({tag, "_frame_err"},   64'(frame_err),   64'd0);
      check({tag, "_frame_cnt"},   64'(frame_cnt),   64'd0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_line(input int y, input int nbytes, input bit drop_vs);
      logic [15:0] pv;
      logic [7:0]  g;
      int          x;
      pv = 16'd0;
      for (int b = 0; b < nbytes; b++) begin
         x = b / 2;
         @(posedge clk);
         #1;
         href = 1'b1;
         if (b % 2 == 0) begin
            pv = pix_value(x, y);
            d  = pv[15:8];
         end else begin
            d = pv[7:0];
`ifdef CAM_CAPTURE_GRAY_EN
            g = gray_of(pv);
`else
            g = 8'd0;
`endif
            if (cap_active && x < H && y < V)
               exp_q.push_back({pv, g, 11'(x), 11'(y), 32'(cyc + 2)});
         end
         if (drop_vs && b == nbytes - 1) vs = 1'b0;
      end
      @(posedge clk);
      #1;
      href = 1'b0;
      d    = 8'd0;
      if (cap_active && nbytes != 2 * H) exp_le++;
      idle(3);
   endtask

   task automatic drive_frame(input string tag, input int nlines, input bit drop_last,
                              input int rst_line, input int raise_line);
      @(posedge clk);
      #1;
      vs = 1'b1;
      cap_active = cap_en;
      if (cap_active) exp_fs++;
      idle(3);
      for (int l = 0; l < nlines; l++) begin
         if (l == raise_line) cap_en = 1'b1;
         if (l == rst_line) begin
            idle(4);
            drain_compare({tag, "_pre_reset"});
            rst = 1'b1;
            idle(2);
            @(negedge clk);
            check_zero({tag, "_mid_reset"});
            @(posedge clk);
            #1;
            rst        = 1'b0;
            cap_active = 1'b0;
            exp_cnt    = 0;
         end
         drive_line(l, line_bytes[l], drop_last && (l == nlines - 1));
      end
      if (!drop_last) begin
         @(posedge clk);
         #1;
         vs = 1'b0;
      end
      if (cap_active) begin
         exp_fe++;
         exp_cnt = (exp_cnt + 1) % 256;
         if (nlines != V) exp_ferr++;
      end
      idle(6);
      @(negedge clk);
      check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt));
      drain_compare(tag);
      check_events(tag);
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 64; i++) line_bytes[i] = 2 * H;

      rst = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(4);

      // Full frame, index pattern.
      cap_en   = 1'b1;
      pat_mode = 0;
      drive_frame("full_idx", V, 1'b0, -1, -1);

      // Known colours up front; VSYNC falls with the final low byte.
      pat_mode = 2;
      drive_frame("gray_vs_last", V, 1'b1, -1, -1);
      check("fe_with_last_pix", 64'(fe_cyc), 64'(last_pix_cyc));

      // One odd-length line and one over-long line.
      pat_mode      = 1;
      line_bytes[2] = 2 * H - 1;
      line_bytes[5] = 2 * H + $urandom_range(2, 6);
      drive_frame("bad_lines", V, 1'b0, -1, -1);
      line_bytes[2] = 2 * H;
      line_bytes[5] = 2 * H;

      // Short frame then a normal one.
      drive_frame("short_frame", 5, 1'b0, -1, -1);
      drive_frame("after_short", V, 1'b0, -1, -1);

      // Capture disabled at frame start, enabled mid-frame.
      cap_en = 1'b0;
      drive_frame("cap_off", V, 1'b0, -1, 3);
      drive_frame("cap_on", V, 1'b0, -1, -1);

      // Reset in the middle of a frame, then a clean frame.
      drive_frame("reset_mid", V, 1'b0, 4, -1);
      drive_frame("after_reset", V, 1'b0, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
